// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with NRD combinational read
// ports, one write port, optional write-to-read bypass and a per-register
// busy scoreboard used by the control FSM for read-after-write stalls.

// One read port: bypass mux plus scoreboard lookup for its address.
module regfile_sb_rdport #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic [NREGS-1:0][XLEN-1:0] regs_i,
    input  logic [NREGS-1:0]           busy_i,
    input  logic [AW-1:0]              ra_i,
    input  logic                       we_i,
    input  logic                       wclr_i,
    input  logic [AW-1:0]              wa_i,
    input  logic [XLEN-1:0]            wd_i,
    output logic [XLEN-1:0]            rd_o,
    output logic                       rbusy_o
);
    logic hit;

    // Same-cycle write to this port's address (never x0) forwards wd.
    assign hit = (BYPASS != 0) && we_i && (wa_i == ra_i) && (wa_i != {AW{1'b0}});

    // Read data and busy view; x0 is always zero and never busy.
    always_comb begin
        rd_o    = {XLEN{1'b0}};
        rbusy_o = 1'b0;
        if (hit) begin
            rd_o    = wd_i;
            rbusy_o = wclr_i ? 1'b0 : busy_i[ra_i];
        end else if (ra_i != {AW{1'b0}}) begin
            rd_o    = regs_i[ra_i];
            rbusy_o = busy_i[ra_i];
        end
    end
endmodule

module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*AW-1:0]     ra,
    output logic [NRD*XLEN-1:0]   rd,
    output logic [NRD-1:0]        rbusy,
    input  logic                  we,
    input  logic [AW-1:0]         wa,
    input  logic [XLEN-1:0]       wd,
    input  logic                  wclr,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rd,
    output logic                  iss_ready,
    output logic [AW:0]           busy_cnt
);
    logic [NREGS-1:0][XLEN-1:0] regs_q;
    logic [NREGS-1:0]           busy_q, busy_d;
    logic [AW:0]                cnt_q, cnt_d;
    logic                       wr_en, clr_en, iss_acc;

    assign wr_en   = we && (wa != {AW{1'b0}});
    assign clr_en  = wr_en && wclr;
    // A busy register may be re-issued in the cycle its writer retires.
    assign iss_ready = (iss_rd == {AW{1'b0}}) || !busy_q[iss_rd] ||
                       (we && wclr && (wa == iss_rd));
    assign iss_acc = iss_valid && iss_ready && (iss_rd != {AW{1'b0}});

    // Register array; x0 is never written so it stays zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '0;
        end else if (wr_en) begin
            regs_q[wa] <= wd;
        end
    end

    // Scoreboard next state: clear on writeback, then set on issue so a
    // new owner issued in the retiring cycle keeps the bit.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[wa] = 1'b0;
        if (iss_acc) busy_d[iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
        cnt_d = {(AW+1){1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            cnt_d = cnt_d + (AW+1)'(busy_d[i]);
        end
    end

    // Scoreboard bits and their registered popcount.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_sb_rdport #(
            .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .BYPASS(BYPASS)
        ) u_rdport (
            .regs_i (regs_q),
            .busy_i (busy_q),
            .ra_i   (ra[k*AW +: AW]),
            .we_i   (we),
            .wclr_i (wclr),
            .wa_i   (wa),
            .wd_i   (wd),
            .rd_o   (rd[k*XLEN +: XLEN]),
            .rbusy_o(rbusy[k])
        );
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default build (bypass), a no-bypass
// build sharing the same inputs, and a 64-bit/16-reg/3-port build.
module tb_regfile_sb;
    logic clk, reset;
    int checks = 0;
    int errors = 0;

    // Builds A (BYPASS=1) and B (BYPASS=0) share inputs.
    logic [4:0]  ra0, ra1, wa, iss_rd;
    logic        we, wclr, iss_valid;
    logic [31:0] wd;
    logic [63:0] rd_a, rd_b;
    logic [1:0]  rbusy_a, rbusy_b;
    logic        rdy_a, rdy_b;
    logic [5:0]  cnt_a, cnt_b;

    // Build C: XLEN=64, NREGS=16, NRD=3.
    logic [3:0]   rc0, rc1, rc2, wa_c, iss_rd_c;
    logic         we_c, wclr_c, iss_valid_c;
    logic [63:0]  wd_c;
    logic [191:0] rd_c;
    logic [2:0]   rbusy_c;
    logic         rdy_c;
    logic [4:0]   cnt_c;

    regfile_sb u_a (
        .clk(clk), .reset(reset), .ra({ra1, ra0}), .rd(rd_a), .rbusy(rbusy_a),
        .we(we), .wa(wa), .wd(wd), .wclr(wclr), .iss_valid(iss_valid),
        .iss_rd(iss_rd), .iss_ready(rdy_a), .busy_cnt(cnt_a)
    );

    regfile_sb #(.BYPASS(0)) u_b (
        .clk(clk), .reset(reset), .ra({ra1, ra0}), .rd(rd_b), .rbusy(rbusy_b),
        .we(we), .wa(wa), .wd(wd), .wclr(wclr), .iss_valid(iss_valid),
        .iss_rd(iss_rd), .iss_ready(rdy_b), .busy_cnt(cnt_b)
    );

    regfile_sb #(.XLEN(64), .NREGS(16), .NRD(3)) u_c (
        .clk(clk), .reset(reset), .ra({rc2, rc1, rc0}), .rd(rd_c), .rbusy(rbusy_c),
        .we(we_c), .wa(wa_c), .wd(wd_c), .wclr(wclr_c), .iss_valid(iss_valid_c),
        .iss_rd(iss_rd_c), .iss_ready(rdy_c), .busy_cnt(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        ra0 = 0; ra1 = 0; wa = 0; iss_rd = 0; we = 0; wclr = 0; iss_valid = 0; wd = 0;
        rc0 = 0; rc1 = 0; rc2 = 0; wa_c = 0; iss_rd_c = 0; we_c = 0; wclr_c = 0;
        iss_valid_c = 0; wd_c = 0;
        #12;
        chk("rst_cnt", cnt_a, 0);
        chk("rst_ready", rdy_a, 1);
        chk("rst_rd", rd_a, 0);
        chk("rst_rbusy", rbusy_a, 0);
        reset = 1'b0;

        // Write x5 and reserve it, then reset mid-cycle.
        ra0 = 5; we = 1; wa = 5; wd = 32'hDEADBEEF; iss_valid = 1; iss_rd = 5;
        tick();
        we = 0; iss_valid = 0;
        #1;
        chk("x5_rd", rd_a[31:0], 32'hDEADBEEF);
        chk("x5_busy_cnt", cnt_a, 1);
        chk("x5_rbusy", rbusy_a[0], 1);
        chk("x5_not_ready", rdy_a, 0);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_rd", rd_a[31:0], 0);
        chk("async_rst_cnt", cnt_a, 0);
        chk("async_rst_ready", rdy_a, 1);
        chk("async_rst_rbusy", rbusy_a[0], 0);
        reset = 1'b0;
        tick();

        // x0 is hardwired: write and issue both ignored.
        ra0 = 0; we = 1; wa = 0; wd = 32'h12345678; iss_valid = 1; iss_rd = 0;
        #1;
        chk("x0_bypass_blocked", rd_a[31:0], 0);
        chk("x0_ready", rdy_a, 1);
        tick();
        we = 0; iss_valid = 0;
        #1;
        chk("x0_rd", rd_a[31:0], 0);
        chk("x0_rbusy", rbusy_a[0], 0);
        chk("x0_cnt", cnt_a, 0);

        // Bypass vs stored read of x7.
        we = 1; wa = 7; wd = 32'h11111111;
        tick();
        ra0 = 7; wa = 7; wd = 32'hA5A5A5A5;
        #1;
        chk("byp_a_same_cycle", rd_a[31:0], 32'hA5A5A5A5);
        chk("nobyp_b_old", rd_b[31:0], 32'h11111111);
        tick();
        we = 0;
        #1;
        chk("nobyp_b_after_edge", rd_b[31:0], 32'hA5A5A5A5);

        // Scoreboard hazard on x3.
        ra1 = 3; iss_valid = 1; iss_rd = 3;
        #1;
        chk("x3_ready_first", rdy_a, 1);
        chk("x3_rbusy_pre", rbusy_a[1], 0);
        tick();
        chk("x3_rbusy_post", rbusy_a[1], 1);
        chk("x3_cnt", cnt_a, 1);
        chk("x3_second_not_ready", rdy_a, 0);
        tick();
        chk("x3_cnt_held", cnt_a, 1);
        iss_valid = 0; we = 1; wclr = 1; wa = 3; wd = 32'h42;
        #1;
        chk("wb_a_rbusy_same", rbusy_a[1], 0);
        chk("wb_b_rbusy_same", rbusy_b[1], 1);
        chk("wb_a_rd_fwd", rd_a[63:32], 32'h42);
        chk("wb_ready", rdy_a, 1);
        tick();
        we = 0; wclr = 0;
        #1;
        chk("wb_b_rbusy_after", rbusy_b[1], 0);
        chk("wb_cnt", cnt_a, 0);
        chk("wb_b_rd", rd_b[63:32], 32'h42);

        // Writeback and re-issue of busy x9 in the same cycle.
        ra0 = 9; iss_valid = 1; iss_rd = 9;
        tick();
        chk("x9_cnt", cnt_a, 1);
        we = 1; wclr = 1; wa = 9; wd = 32'h99;
        #1;
        chk("x9_reissue_ready", rdy_a, 1);
        tick();
        we = 0; wclr = 0; iss_valid = 0;
        #1;
        chk("x9_still_busy", rbusy_a[0], 1);
        chk("x9_cnt_same", cnt_a, 1);
        chk("x9_data", rd_a[31:0], 32'h99);

        // Clear to a non-busy register leaves the count alone.
        we = 1; wclr = 1; wa = 10; wd = 32'h10;
        tick();
        we = 0; wclr = 0;
        #1;
        chk("clr_idle_cnt", cnt_a, 1);

        // Wide build: independent reads on three ports.
        we_c = 1;
        wa_c = 1;  wd_c = 64'h0123456789ABCDEF; tick();
        wa_c = 2;  wd_c = 64'hFEDCBA9876543210; tick();
        wa_c = 15; wd_c = 64'hAAAA5555AAAA5555; tick();
        we_c = 0;
        rc0 = 1; rc1 = 2; rc2 = 15;
        #1;
        chk("c_port0", rd_c[63:0], 64'h0123456789ABCDEF);
        chk("c_port1", rd_c[127:64], 64'hFEDCBA9876543210);
        chk("c_port2", rd_c[191:128], 64'hAAAA5555AAAA5555);
        rc0 = 15; rc1 = 1; rc2 = 0;
        #1;
        chk("c_swap_port0", rd_c[63:0], 64'hAAAA5555AAAA5555);
        chk("c_swap_port1", rd_c[127:64], 64'h0123456789ABCDEF);
        chk("c_swap_port2", rd_c[191:128], 64'h0);

        // Fill x1..x15 busy.
        iss_valid_c = 1;
        for (int i = 1; i < 16; i++) begin
            iss_rd_c = 4'(i);
            tick();
        end
        iss_valid_c = 0;
        rc0 = 1; rc1 = 8; rc2 = 15;
        #1;
        chk("c_cnt_full", cnt_c, 15);
        chk("c_rbusy_all", rbusy_c, 3'b111);
        chk("c_ready_busy", rdy_c, 0);
        iss_rd_c = 0;
        #1;
        chk("c_ready_x0", rdy_c, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
